// File: rtl/argmax_sequencer_if.sv
// Bus bundle between the argmax sequencer, the result buffer and the 4-lane argmax comparator.
interface argmax_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6
);
  logic                  start;
  logic                  abort;
  logic [ADDR_W-1:0]     cfg_groups;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [4*DATA_W-1:0]   rd_data;
  logic                  cmp_enable;
  logic                  cmp_trig;
  logic                  cmp_reset;
  logic [DATA_W-1:0]     cmp_in1;
  logic [DATA_W-1:0]     cmp_in2;
  logic [DATA_W-1:0]     cmp_in3;
  logic [DATA_W-1:0]     cmp_in4;
  logic [7:0]            cmp_index;
  logic [7:0]            cmp_largest_8bit;
  logic [7:0]            result_index;
  logic [7:0]            result_value;
  logic                  result_valid;
  logic [15:0]           perf_cycles;

  // Sequencer side
  modport master (
    input  start, abort, cfg_groups, rd_data, cmp_index, cmp_largest_8bit,
    output busy, done, rd_en, rd_addr, cmp_enable, cmp_trig, cmp_reset,
    output cmp_in1, cmp_in2, cmp_in3, cmp_in4,
    output result_index, result_value, result_valid, perf_cycles
  );

  // Environment side (controller, buffer, comparator)
  modport slave (
    output start, abort, cfg_groups, rd_data, cmp_index, cmp_largest_8bit,
    input  busy, done, rd_en, rd_addr, cmp_enable, cmp_trig, cmp_reset,
    input  cmp_in1, cmp_in2, cmp_in3, cmp_in4,
    input  result_index, result_value, result_valid, perf_cycles
  );
endinterface

// File: rtl/argmax_sequencer.sv
// Sequences the 4-lane argmax comparator over cfg_groups buffer words and latches the winner.
// Optional run-cycle counter on perf_cycles enabled by defining ARGMAX_PERF_EN.
module argmax_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6
) (
  input logic                clk,
  input logic                reset_n,
  argmax_sequencer_if.master bus
);

  localparam int unsigned LANES  = 4;
  localparam int unsigned PERF_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_READ, S_LOAD, S_TRIG, S_HOLD, S_DRAIN, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   g_q, grp_q, grp_nxt;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [DATA_W-1:0]   lane_q [LANES];
  logic [7:0]          result_index_q, result_value_q;
  logic                result_valid_q;
  logic                accept_c;
  logic                busy_q, done_q, rd_en_q, cmp_enable_q, cmp_trig_q, cmp_reset_q;
  logic                busy_nxt, done_nxt, rd_en_nxt, cmp_enable_nxt, cmp_trig_nxt, cmp_reset_nxt;

  assign accept_c = (state == S_IDLE) && bus.start;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state and group counter; abort overrides everything outside IDLE
  always_comb begin
    state_nxt = state;
    grp_nxt   = grp_q;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          grp_nxt   = '0;
          state_nxt = (bus.cfg_groups == '0) ? S_DONE : S_CLR;
        end
      end
      S_CLR:   state_nxt = S_READ;
      S_READ:  state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_TRIG;
      S_TRIG:  state_nxt = S_HOLD;
      S_HOLD: begin
        if (grp_q == g_q - ADDR_W'(1)) begin
          state_nxt = S_DRAIN;
        end else begin
          grp_nxt   = grp_q + ADDR_W'(1);
          state_nxt = S_READ;
        end
      end
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  // Control outputs decoded from the upcoming state so the registers line up with it
  always_comb begin
    busy_nxt       = 1'b0;
    done_nxt       = 1'b0;
    rd_en_nxt      = 1'b0;
    cmp_enable_nxt = 1'b0;
    cmp_trig_nxt   = 1'b0;
    cmp_reset_nxt  = 1'b0;
    case (state_nxt)
      S_CLR:   begin busy_nxt = 1'b1; cmp_enable_nxt = 1'b1; cmp_reset_nxt = 1'b1; end
      S_READ:  begin busy_nxt = 1'b1; cmp_enable_nxt = 1'b1; rd_en_nxt     = 1'b1; end
      S_LOAD:  begin busy_nxt = 1'b1; cmp_enable_nxt = 1'b1; end
      S_TRIG:  begin busy_nxt = 1'b1; cmp_enable_nxt = 1'b1; cmp_trig_nxt  = 1'b1; end
      S_HOLD:  begin busy_nxt = 1'b1; cmp_enable_nxt = 1'b1; end
      S_DRAIN: begin busy_nxt = 1'b1; cmp_enable_nxt = 1'b1; end
      S_DONE:  begin busy_nxt = 1'b1; done_nxt       = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      cmp_enable_q <= 1'b0;
      cmp_trig_q   <= 1'b0;
      cmp_reset_q  <= 1'b0;
    end else begin
      busy_q       <= busy_nxt;
      done_q       <= done_nxt;
      rd_en_q      <= rd_en_nxt;
      cmp_enable_q <= cmp_enable_nxt;
      cmp_trig_q   <= cmp_trig_nxt;
      cmp_reset_q  <= cmp_reset_nxt;
    end
  end

  // Datapath: group bookkeeping, lane capture and result latching
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_q            <= '0;
      grp_q          <= '0;
      rd_addr_q      <= '0;
      result_index_q <= '0;
      result_value_q <= '0;
      result_valid_q <= 1'b0;
      for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
    end else begin
      grp_q <= grp_nxt;
      if (accept_c) g_q <= bus.cfg_groups;
      if (state_nxt == S_READ) rd_addr_q <= grp_nxt;
      if ((state == S_LOAD) && (state_nxt == S_TRIG)) begin
        for (int k = 0; k < LANES; k++) lane_q[k] <= bus.rd_data[DATA_W*k +: DATA_W];
      end
      if (state_nxt == S_CLR)       result_valid_q <= 1'b0;
      else if (state_nxt == S_DONE) result_valid_q <= 1'b1;
      if ((state == S_DRAIN) && (state_nxt == S_DONE)) begin
        result_index_q <= bus.cmp_index;
        result_value_q <= bus.cmp_largest_8bit;
      end else if (accept_c && (bus.cfg_groups == '0)) begin
        result_index_q <= '0;
        result_value_q <= '0;
      end
    end
  end

`ifdef ARGMAX_PERF_EN
  logic [PERF_W-1:0] perf_cnt_q, perf_cnt_nxt, perf_q;

  // The accepting edge already counts the first busy cycle; saturates at all-ones
  always_comb begin
    perf_cnt_nxt = perf_cnt_q;
    if (accept_c) begin
      perf_cnt_nxt = PERF_W'(1);
    end else if ((state != S_IDLE) && (perf_cnt_q != {PERF_W{1'b1}})) begin
      perf_cnt_nxt = perf_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cnt_q <= '0;
      perf_q     <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_nxt;
      if (state_nxt == S_DONE) perf_q <= perf_cnt_nxt;
    end
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = PERF_W'(0);
`endif

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.rd_en        = rd_en_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.cmp_enable   = cmp_enable_q;
  assign bus.cmp_trig     = cmp_trig_q;
  assign bus.cmp_reset    = cmp_reset_q;
  assign bus.cmp_in1      = lane_q[0];
  assign bus.cmp_in2      = lane_q[1];
  assign bus.cmp_in3      = lane_q[2];
  assign bus.cmp_in4      = lane_q[3];
  assign bus.result_index = result_index_q;
  assign bus.result_value = result_value_q;
  assign bus.result_valid = result_valid_q;

endmodule
